// File: rtl/data_mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// data_mem_arbiter_if
//
// Bundles every bus signal around the data memory arbiter: the CPU request
// bundle, the DMA/loader request bundle and the command/return lines to the
// single data_memory instance.
//
// Modports:
//   slave  - the arbiter: takes both request bundles and mem_data_out,
//            drives grants, stall, read returns and the memory command.
//   master - the surrounding system (requesters plus data_memory), the
//            mirror image of slave.
//
// Signals:
//   cpu_req/cpu_we/cpu_addr/cpu_wdata   CPU request bundle
//   cpu_gnt/cpu_stall                   CPU grant and stall
//   cpu_rvalid/cpu_rdata                CPU read return
//   dma_req/dma_we/dma_addr/dma_wdata   DMA request bundle
//   dma_gnt                             DMA grant
//   dma_rvalid/dma_rdata                DMA read return
//   mem_read/mem_write/mem_addr/
//   mem_data_in                         command to data_memory
//   mem_data_out                        data_memory read data (one cycle later)
// ----------------------------------------------------------------------------
interface data_mem_arbiter_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_stall;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_gnt;
    logic              dma_rvalid;
    logic [DATA_W-1:0] dma_rdata;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_gnt, dma_rvalid, dma_rdata,
        output mem_read, mem_write, mem_addr, mem_data_in,
        input  mem_data_out
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  mem_read, mem_write, mem_addr, mem_data_in,
        output mem_data_out
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// ----------------------------------------------------------------------------
// data_mem_arbiter
//
// Shares one data_memory between the CPU load/store path and a DMA/loader
// port. One access is granted per cycle. The CPU normally wins contention,
// but once the DMA port has been denied STARVE_LIMIT consecutive cycles it
// wins the next contended cycle. Read data coming back from the memory one
// cycle after the access is steered to the port that issued the read.
//
// Ports:
//   clk    - system clock, all state changes on the rising edge
//   reset  - asynchronous, active-high reset
//   bus    - data_mem_arbiter_if.slave (request bundles, grants, stall,
//            read returns and the memory command/return lines)
//
// Parameters:
//   ADDR_W       - memory address width
//   DATA_W       - memory data width
//   STARVE_LIMIT - denied DMA cycles before DMA wins contention (1..15)
// ----------------------------------------------------------------------------
module data_mem_arbiter #(
    parameter int ADDR_W       = 6,
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    data_mem_arbiter_if.slave     bus
);

    localparam logic [3:0] STARVE_MAX = 4'd15;
    localparam logic [3:0] LIMIT      = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_CPU  = 2'd1,
        OWNER_DMA  = 2'd2
    } owner_t;

    owner_t            rd_owner;
    owner_t            rd_owner_next;
    logic [3:0]        starve_cnt;
    logic [3:0]        starve_next;
    logic              cpu_win;
    logic              dma_win;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Grant selection: a lone requester always wins; under contention the
    // CPU wins unless the DMA port has waited long enough.
    always_comb begin
        cpu_win = 1'b0;
        dma_win = 1'b0;
        if (bus.cpu_req && bus.dma_req) begin
            if (starve_cnt >= LIMIT) begin
                dma_win = 1'b1;
            end else begin
                cpu_win = 1'b1;
            end
        end else if (bus.cpu_req) begin
            cpu_win = 1'b1;
        end else if (bus.dma_req) begin
            dma_win = 1'b1;
        end
    end

    assign bus.cpu_gnt   = cpu_win;
    assign bus.dma_gnt   = dma_win;
    assign bus.cpu_stall = bus.cpu_req & ~cpu_win;

    // Forward the winning port's command to the memory; with no winner
    // the memory sees an all-zero, inactive command.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (cpu_win) begin
            sel_we    = bus.cpu_we;
            sel_addr  = bus.cpu_addr;
            sel_wdata = bus.cpu_wdata;
        end else if (dma_win) begin
            sel_we    = bus.dma_we;
            sel_addr  = bus.dma_addr;
            sel_wdata = bus.dma_wdata;
        end
    end

    assign bus.mem_write   = (cpu_win | dma_win) & sel_we;
    assign bus.mem_read    = (cpu_win | dma_win) & ~sel_we;
    assign bus.mem_addr    = sel_addr;
    assign bus.mem_data_in = sel_wdata;

    // The starvation counter only counts an unbroken run of denied DMA
    // requests; a grant or a withdrawn request starts the run over.
    always_comb begin
        starve_next = starve_cnt;
        if (!bus.dma_req || dma_win) begin
            starve_next = 4'd0;
        end else if (starve_cnt != STARVE_MAX) begin
            starve_next = starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= 4'd0;
        end else begin
            starve_cnt <= starve_next;
        end
    end

    // Remember who issued this cycle's read so the memory's registered
    // data can be steered back next cycle. Writes and idle cycles leave
    // nothing to return.
    always_comb begin
        rd_owner_next = OWNER_NONE;
        if (cpu_win && !bus.cpu_we) begin
            rd_owner_next = OWNER_CPU;
        end else if (dma_win && !bus.dma_we) begin
            rd_owner_next = OWNER_DMA;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_owner <= OWNER_NONE;
        end else begin
            rd_owner <= rd_owner_next;
        end
    end

    // Read returns are gated by the registered owner so a non-owning port
    // always sees zero data, and reset drops any return in flight at once.
    always_comb begin
        bus.cpu_rvalid = 1'b0;
        bus.cpu_rdata  = '0;
        bus.dma_rvalid = 1'b0;
        bus.dma_rdata  = '0;
        if (rd_owner == OWNER_CPU) begin
            bus.cpu_rvalid = 1'b1;
            bus.cpu_rdata  = bus.mem_data_out;
        end else if (rd_owner == OWNER_DMA) begin
            bus.dma_rvalid = 1'b1;
            bus.dma_rdata  = bus.mem_data_out;
        end
    end

endmodule
